// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the instruction/data memory request arbiter.
// Port IDs, FSM encoding, default outstanding depth and the request payload bundle.
package mem_req_arbiter_pkg;

  localparam int unsigned OT_DEPTH_DEF = 4;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic arb_state_e grant_state(input logic port);
    return (port == PORT_DATA) ? ST_GRANT_D : ST_GRANT_I;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_resp_order_fifo.sv
// Response-order FIFO: remembers which port issued each outstanding request.
// One bit per entry; push and pop may happen together, including when full.
module resp_order_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     push_id_i,
  input  logic                     pop_i,
  output logic                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] id_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = id_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees the head slot before the push claims one, so push-on-full is safe.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        id_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port (inst/data) arbiter onto one sram-like downstream bus with in-order responses.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data-port priority.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned OT_DEPTH = OT_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_e state_q, state_d;

  mem_req_t inst_pl;
  mem_req_t data_pl;
  mem_req_t mem_pl;

  logic win_port;
  logic grant_port;
  logic port_req;
  logic can_push;
  logic accept;
  logic pop;

  logic                      fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(OT_DEPTH):0] ot_count_unused;

  assign inst_pl = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                     addr: inst_addr, wdata: inst_wdata};
  assign data_pl = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                     addr: data_addr, wdata: data_wdata};

`ifdef ARB_RR_EN
  logic rr_prio_q, rr_prio_d;

  always_comb begin
    if (inst_req && data_req) begin
      win_port = rr_prio_q;
    end else if (data_req) begin
      win_port = PORT_DATA;
    end else begin
      win_port = PORT_INST;
    end
  end

  // Priority flips away from whoever just got a request accepted.
  assign rr_prio_d = accept ? ((grant_port == PORT_DATA) ? PORT_INST : PORT_DATA)
                            : rr_prio_q;
`else
  assign win_port = data_req ? PORT_DATA : PORT_INST;
`endif

  always_comb begin
    grant_port = win_port;
    port_req   = inst_req || data_req;
    case (state_q)
      ST_GRANT_I: begin
        grant_port = PORT_INST;
        port_req   = inst_req;
      end
      ST_GRANT_D: begin
        grant_port = PORT_DATA;
        port_req   = data_req;
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet during the reset cycle so nothing leaks downstream.
  assign pop      = mem_data_ok && !fifo_empty && !reset;
  assign can_push = !fifo_full || pop;
  assign mem_req  = port_req && can_push && !reset;
  assign accept   = mem_req && mem_addr_ok;

  assign mem_pl    = (grant_port == PORT_DATA) ? data_pl : inst_pl;
  assign mem_wr    = mem_pl.wr;
  assign mem_size  = mem_pl.size;
  assign mem_wstrb = mem_pl.wstrb;
  assign mem_addr  = mem_pl.addr;
  assign mem_wdata = mem_pl.wdata;

  assign inst_addr_ok = accept && (grant_port == PORT_INST);
  assign data_addr_ok = accept && (grant_port == PORT_DATA);

  assign inst_data_ok = pop && (fifo_head == PORT_INST);
  assign data_data_ok = pop && (fifo_head == PORT_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_d = grant_state(win_port);
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (!port_req || accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef ARB_RR_EN
      rr_prio_q <= PORT_DATA;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_RR_EN
      rr_prio_q <= rr_prio_d;
`endif
    end
  end

  resp_order_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (accept),
    .push_id_i (grant_port),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (ot_count_unused)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: arbitration, grant hold, FIFO limits, ordering, reset.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [3:0]  inst_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.OT_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; data_req = 0; data_wr = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    @(negedge clk); #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    n_cmp++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok got %b%b want 00", inst_addr_ok, data_addr_ok); end
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_ok got %b%b want 00", inst_data_ok, data_data_ok); end
    @(negedge clk); reset = 0; idle_inputs(); #1;
    n_cmp++; if (dut.u_fifo.count_o !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", dut.u_fifo.count_o); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_mem_req got %b want 0", mem_req); end
  endtask

  // Both ports hammer the bus with responses streaming back each cycle.
  task automatic test_arb_pattern();
    logic [3:0] exp_d;
`ifdef ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inst_req = 1; data_req = 1; inst_addr = 32'h100 + k; data_addr = 32'h200 + k;
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h5000 + k;
      #1;
      n_cmp++; if (data_addr_ok !== exp_d[k] || inst_addr_ok !== !exp_d[k]) begin n_err++; $display("FAIL arb_grant_c%0d got d%b i%b want d%b", k, data_addr_ok, inst_addr_ok, exp_d[k]); end
      n_cmp++; if (mem_addr !== (exp_d[k] ? 32'h200 + k : 32'h100 + k)) begin n_err++; $display("FAIL arb_addr_c%0d got %h", k, mem_addr); end
      if (k == 0) begin
        n_cmp++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin n_err++; $display("FAIL arb_empty_pop got d%b i%b want 00", data_data_ok, inst_data_ok); end
      end else begin
        n_cmp++; if (data_data_ok !== exp_d[k-1] || inst_data_ok !== !exp_d[k-1]) begin n_err++; $display("FAIL arb_resp_c%0d got d%b i%b want d%b", k, data_data_ok, inst_data_ok, exp_d[k-1]); end
      end
    end
    @(negedge clk); idle_inputs(); mem_data_ok = 1; #1;
    n_cmp++; if (data_data_ok !== exp_d[3] || inst_data_ok !== !exp_d[3]) begin n_err++; $display("FAIL arb_resp_last got d%b i%b want d%b", data_data_ok, inst_data_ok, exp_d[3]); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (dut.u_fifo.count_o !== 3'd0) begin n_err++; $display("FAIL arb_drain_count got %0d want 0", dut.u_fifo.count_o); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    inst_req = 1; data_req = 1; inst_addr = 32'h1c000040; data_addr = 32'h00002000; mem_addr_ok = 1; #1;
    n_cmp++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL prio_c0 got d%b i%b want d1 i0", data_addr_ok, inst_addr_ok); end
    n_cmp++; if (mem_addr !== 32'h00002000) begin n_err++; $display("FAIL prio_c0_addr got %h want 00002000", mem_addr); end
    @(negedge clk); data_req = 0; #1;
    n_cmp++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c000040) begin n_err++; $display("FAIL prio_c1 got i%b addr %h want i1 1c000040", inst_addr_ok, mem_addr); end
    @(negedge clk); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h11; #1;
    n_cmp++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'h11) begin n_err++; $display("FAIL prio_resp0 got d%b i%b %h want d1 i0 11", data_data_ok, inst_data_ok, data_rdata); end
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h22; #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h22) begin n_err++; $display("FAIL prio_resp1 got i%b d%b %h want i1 d0 22", inst_data_ok, data_data_ok, inst_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_hold();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      data_req = (k < 4); data_addr = 32'h00001000; data_wdata = 32'hD00D0000;
      inst_req = (k >= 1); inst_addr = 32'h1c000100;
      mem_addr_ok = (k >= 3); #1;
      if (k < 4) begin
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h00001000 || mem_wdata !== 32'hD00D0000) begin n_err++; $display("FAIL hold_c%0d got req%b %h want req1 00001000", k, mem_req, mem_addr); end
        n_cmp++; if (data_addr_ok !== (k == 3) || inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL hold_ok_c%0d got d%b i%b", k, data_addr_ok, inst_addr_ok); end
      end else begin
        n_cmp++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c000100) begin n_err++; $display("FAIL hold_inst got i%b %h want i1 1c000100", inst_addr_ok, mem_addr); end
      end
      if (k == 3) begin
        @(negedge clk); data_req = 0; #1;
        n_cmp++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c000100) begin n_err++; $display("FAIL hold_c4 got i%b %h want i1 1c000100", inst_addr_ok, mem_addr); end
        break;
      end
    end
    @(negedge clk); idle_inputs(); mem_data_ok = 1; #1;
    n_cmp++; if (data_data_ok !== 1'b1) begin n_err++; $display("FAIL hold_resp0 got %b want 1", data_data_ok); end
    @(negedge clk); mem_data_ok = 1; #1;
    n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL hold_resp1 got %b want 1", inst_data_ok); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_interleave();
    @(negedge clk); inst_req = 1; inst_wr = 0; inst_addr = 32'h1c000000; mem_addr_ok = 1; #1;
    n_cmp++; if (inst_addr_ok !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL il_i0 got ok%b wr%b want 1 0", inst_addr_ok, mem_wr); end
    @(negedge clk); inst_req = 0; data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_size = 2'd2;
    data_addr = 32'h00001000; data_wdata = 32'h12345678; #1;
    n_cmp++; if (data_addr_ok !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'hF || mem_wdata !== 32'h12345678 || mem_size !== 2'd2) begin n_err++; $display("FAIL il_dw got ok%b wr%b strb%h %h", data_addr_ok, mem_wr, mem_wstrb, mem_wdata); end
    @(negedge clk); data_req = 0; data_wr = 0; inst_req = 1; inst_addr = 32'h1c000004; #1;
    n_cmp++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c000004) begin n_err++; $display("FAIL il_i1 got ok%b %h", inst_addr_ok, mem_addr); end
    @(negedge clk); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'hAAAA; #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hAAAA) begin n_err++; $display("FAIL il_r0 got i%b d%b %h want i1 d0 aaaa", inst_data_ok, data_data_ok, inst_rdata); end
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h0; #1;
    n_cmp++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin n_err++; $display("FAIL il_r1 got d%b i%b want d1 i0", data_data_ok, inst_data_ok); end
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'hBBBB; #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hBBBB) begin n_err++; $display("FAIL il_r2 got i%b d%b %h want i1 d0 bbbb", inst_data_ok, data_data_ok, inst_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); inst_req = 1; inst_addr = 32'h1c000000 + 32'(4 * k); mem_addr_ok = 1; #1;
      n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_fill_c%0d got %b want 1", k, inst_addr_ok); end
    end
    @(negedge clk); #1;
    n_cmp++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL full_block got req%b ok%b want 0 0", mem_req, inst_addr_ok); end
    n_cmp++; if (dut.u_fifo.count_o !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", dut.u_fifo.count_o); end
    @(negedge clk); mem_data_ok = 1; #1;
    n_cmp++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_pushpop got req%b ok%b dok%b want 111", mem_req, inst_addr_ok, inst_data_ok); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); inst_req = 0; mem_data_ok = 1; #1;
      n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_drain_c%0d got %b want 1", k, inst_data_ok); end
    end
    @(negedge clk); mem_data_ok = 1; #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL full_stray got i%b d%b want 00", inst_data_ok, data_data_ok); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (dut.u_fifo.count_o !== 3'd0) begin n_err++; $display("FAIL full_end_count got %0d want 0", dut.u_fifo.count_o); end
  endtask

  task automatic test_drop();
    @(negedge clk); data_req = 1; data_addr = 32'h3000; mem_addr_ok = 0; #1;
    n_cmp++; if (mem_req !== 1'b1 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL drop_c0 got req%b ok%b want 1 0", mem_req, data_addr_ok); end
    @(negedge clk); data_req = 0; inst_req = 1; inst_addr = 32'h1c000200; mem_addr_ok = 1; #1;
    n_cmp++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL drop_c1 got req%b i%b d%b want 000", mem_req, inst_addr_ok, data_addr_ok); end
    @(negedge clk); #1;
    n_cmp++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c000200) begin n_err++; $display("FAIL drop_c2 got ok%b %h want 1 1c000200", inst_addr_ok, mem_addr); end
    @(negedge clk); idle_inputs(); mem_data_ok = 1; #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL drop_resp got i%b d%b want i1 d0", inst_data_ok, data_data_ok); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (dut.u_fifo.count_o !== 3'd0) begin n_err++; $display("FAIL drop_count got %0d want 0", dut.u_fifo.count_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); inst_req = 1; mem_addr_ok = 1;
    @(negedge clk); inst_req = 1; #1;
    n_cmp++; if (dut.u_fifo.count_o !== 3'd1) begin n_err++; $display("FAIL rmid_count1 got %0d want 1", dut.u_fifo.count_o); end
    @(negedge clk); idle_inputs(); reset = 1; mem_data_ok = 1; #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL rmid_during got i%b d%b want 00", inst_data_ok, data_data_ok); end
    @(negedge clk); reset = 0; mem_data_ok = 1; #1;
    n_cmp++; if (dut.u_fifo.count_o !== 3'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", dut.u_fifo.count_o); end
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL rmid_stray got i%b d%b want 00", inst_data_ok, data_data_ok); end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_arb_pattern();
    test_priority();
    test_hold();
    test_interleave();
    test_full();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
